// File: rtl/register_file_sb_pkg.sv
// ============================================================================
// Module : register_file_sb_pkg
// Desc   : Shared defaults and register-number decode for register_file_sb.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package register_file_sb_pkg;

  localparam int c_NUM_REGS  = 16;
  localparam int c_LEN_REG   = 32;
  localparam int c_LEN_REGNO = $clog2(c_NUM_REGS);

  // Decode is sized for the largest supported file; callers truncate to NUM_REGS.
  localparam int c_MAX_REGNO = 8;
  localparam int c_MAX_REGS  = 1 << c_MAX_REGNO;

  function automatic logic [c_MAX_REGS-1:0] decode(input logic [c_MAX_REGNO-1:0] regno);
    logic [c_MAX_REGS-1:0] onehot;
    onehot        = '0;
    onehot[regno] = 1'b1;
    return onehot;
  endfunction

endpackage

`default_nettype wire

// File: rtl/register_cell_sb.sv
// ============================================================================
// Module : register_cell_sb
// Desc   : One architectural register with its scoreboard busy bit.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_cell_sb #(
  parameter int LEN_REG = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [LEN_REG-1:0] i_wdata,
  input  logic               i_set,
  input  logic               i_clr,
  output logic [LEN_REG-1:0] o_data,
  output logic               o_busy
);

  logic [LEN_REG-1:0] r_data;
  logic               r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
      r_busy <= 1'b0;
    end else begin
      if (i_we) r_data <= i_wdata;
      // A new reservation outranks a release of the same register.
      if (i_set)      r_busy <= 1'b1;
      else if (i_clr) r_busy <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/register_file_sb.sv
// ============================================================================
// Module : register_file_sb
// Desc   : Scoreboarded register file with hazard-checked issue, multi-port
//          writeback and writeback-to-read bypass.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_sb
  import register_file_sb_pkg::*;
#(
  parameter int NUM_REGS  = c_NUM_REGS,
  parameter int LEN_REG   = c_LEN_REG,
  parameter int LEN_REGNO = $clog2(NUM_REGS),
  parameter int NUM_WB    = 2,
  parameter int ZERO_REG  = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [LEN_REGNO-1:0]        rs0_i,
  input  logic [LEN_REGNO-1:0]        rs1_i,
  input  logic [1:0]                  rs_use_i,
  input  logic [LEN_REGNO-1:0]        rd_i,
  input  logic                        issue_valid_i,
  input  logic                        issue_wr_i,
  output logic                        issue_ready_o,
  output logic [LEN_REG-1:0]          r_opr0_o,
  output logic [LEN_REG-1:0]          r_opr1_o,
  input  logic [NUM_WB-1:0]           wb_i,
  input  logic [NUM_WB*LEN_REGNO-1:0] wb_r_i,
  input  logic [NUM_WB*LEN_REG-1:0]   result_i,
  output logic [NUM_REGS-1:0]         busy_o,
  output logic [LEN_REGNO:0]          busy_cnt_o
);

  localparam int c_CNT_W = LEN_REGNO + 1;

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_clr_vec;
  logic [NUM_REGS-1:0] w_busy_eff;
  logic [NUM_REGS-1:0] w_we;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_rd_onehot;
  logic [LEN_REG-1:0]  w_wdata [NUM_REGS];
  logic [LEN_REG-1:0]  w_data  [NUM_REGS];
  logic                w_hazard;
  logic                w_fire;

  // Per-register writeback hit and data; later ports override earlier ones.
  always_comb begin
    w_clr_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      w_wdata[r] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_i[k] && (wb_r_i[k*LEN_REGNO +: LEN_REGNO] == LEN_REGNO'(r))) begin
          w_clr_vec[r] = 1'b1;
          w_wdata[r]   = result_i[k*LEN_REG +: LEN_REG];
        end
      end
    end
  end

  assign w_busy_eff = w_busy & ~w_clr_vec;

  assign w_hazard = (rs_use_i[0] & w_busy_eff[rs0_i])
                  | (rs_use_i[1] & w_busy_eff[rs1_i])
                  | (issue_wr_i  & w_busy_eff[rd_i]);

  assign issue_ready_o = ~w_hazard;
  assign w_fire        = issue_valid_i & issue_ready_o;
  assign w_rd_onehot   = NUM_REGS'(decode(c_MAX_REGNO'(rd_i)));

  // Register 0 is kept permanently idle and unwritten when hardwired to zero.
  always_comb begin
    w_we      = w_clr_vec;
    w_set_vec = (w_fire && issue_wr_i) ? w_rd_onehot : '0;
    if (ZERO_REG != 0) begin
      w_we[0]      = 1'b0;
      w_set_vec[0] = 1'b0;
    end
  end

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_cell
    register_cell_sb #(
      .LEN_REG (LEN_REG)
    ) u_cell (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we[r]),
      .i_wdata (w_wdata[r]),
      .i_set   (w_set_vec[r]),
      .i_clr   (w_clr_vec[r]),
      .o_data  (w_data[r]),
      .o_busy  (w_busy[r])
    );
  end

  // Operand read with same-cycle bypass from the highest matching port.
  always_comb begin
    r_opr0_o = w_data[rs0_i];
    r_opr1_o = w_data[rs1_i];
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_i[k] && (wb_r_i[k*LEN_REGNO +: LEN_REGNO] == rs0_i))
        r_opr0_o = result_i[k*LEN_REG +: LEN_REG];
      if (wb_i[k] && (wb_r_i[k*LEN_REGNO +: LEN_REGNO] == rs1_i))
        r_opr1_o = result_i[k*LEN_REG +: LEN_REG];
    end
    if ((ZERO_REG != 0) && (rs0_i == '0)) r_opr0_o = '0;
    if ((ZERO_REG != 0) && (rs1_i == '0)) r_opr1_o = '0;
  end

  always_comb begin
    busy_cnt_o = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_cnt_o = busy_cnt_o + c_CNT_W'(w_busy[i]);
  end

  assign busy_o = w_busy;

endmodule

`default_nettype wire
